hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: Opcode_IFID  input  6, and Funct_IFID  input  6; opcode and funct of the instruction in ID.
REQ-004 SHALL have ports: RsAddr_IFID  input  5, and RtAddr_IFID  input  5; source registers of the ID instruction.
REQ-005 SHALL have ports:
- RdAddr_IDEX  input  5; destination of the EX instruction.
- RegWrite_IDEX  input  1
- MemRead_IDEX  input  1; EX instruction is a load.
REQ-006 SHALL have ports:
- RdAddr_EXMEM  input  5
- MemRead_EXMEM  input  1; MEM instruction is a load.
REQ-007 SHALL have ports: BranchTaken  input  1 (ID compare result), and Jump  input  1 (ID instruction is j/jal/jr).
REQ-008 SHALL have ports: MdStart_IDEX  input  1 (mult/div in EX), and MdIsDiv_IDEX  input  1 (1=div, 0=mult).
REQ-009 SHALL have outputs:
- PCWrite  output  1
- IFIDWrite  output  1
- IFIDFlush  output  1
- IDEXFlush  output  1
REQ-010 SHALL have outputs:
- MdBusy  output  1; registered, mult/div unit occupied.
- StallCount  output  16; registered count of stall cycles.

Function
REQ-011 SHALL define BrAB = Opcode_IFID in {04h,05h} (uses rs,rt) and BrA = Opcode_IFID in {01h,06h,07h} (uses rs only).
REQ-012 SHALL define UsesRt = Opcode_IFID==00h or BrAB or Opcode_IFID==2Bh (sw); all other opcodes use rs only.
REQ-013 SHALL define match(x,r) = (x!=0) && (x==r) for both rs and rt, with rt gated by UsesRt.
REQ-014 SHALL detect LoadUse = MemRead_IDEX && match(RdAddr_IDEX, rs or rt); cost 1 stall cycle.
REQ-015 SHALL detect BrAlu = (BrAB||BrA) && RegWrite_IDEX && !MemRead_IDEX && match(RdAddr_IDEX, branch sources); cost 1 stall.
REQ-016 SHALL detect BrLoad:
- EX-stage load matching a branch source costs 2 stalls (LoadUse then BrLdMem).
- BrLdMem = (BrAB||BrA) && MemRead_EXMEM && match(RdAddr_EXMEM, branch sources); cost 1 stall.
REQ-017 SHALL detect MdHaz = MdBusy_next-cycle-view (MdBusy || MdStart_IDEX) && Opcode_IFID==00h && Funct_IFID in {10h,12h,18h,19h,1Ah,1Bh}.
REQ-018 SHALL set Stall = LoadUse || BrAlu || BrLdMem || MdHaz.
REQ-019 SHALL, when Stall: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0, all combinational in the same cycle.
REQ-020 SHALL, when !Stall && (Jump || ((BrAB||BrA) && BrankTaken)): PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=0.
REQ-021 SHALL, when Stall and BranchTaken/Jump coincide, ignore BranchTaken/Jump; stall wins.
REQ-022 SHALL otherwise output PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
REQ-023 SHALL implement FSM {RUN, MDW}:
- RUN->MDW when MdStart_IDEX: load MdCnt = 32 if MdIsDiv_IDEX, else 4.
- MDW decrements MdCnt each cycle and returns to RUN in the cycle MdCnt reaches 1.
- MdBusy=1 exactly while in MDW.
REQ-024 SHALL ignore MdStart_IDEX while in MDW; no reload, no restart.
REQ-025 SHALL increment StallCount by 1 on every clock edge where Stall=1, saturating at FFFFh.

Reset
REQ-026 SHALL, on rising clk with rst_n=0: state=RUN, MdCnt=0, MdBusy=0, StallCount=0.
REQ-027 SHALL abort any mult/div wait when reset occurs mid-MDW.
REQ-028 SHALL, while rst_n=0, force PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1 regardless of other inputs.

Verification
REQ-029 SHALL cover load-use:
- Stimulus: MemRead_IDEX=1, RdAddr_IDEX=8; ID is add with rs=8.
- Response: 1 cycle PCWrite=0, IDEXFlush=1; StallCount 0->1.
REQ-030 SHALL cover branch after load:
- Stimulus: lw $9 in EX; beq rs=9 in ID.
- Response: 2 consecutive stall cycles, then BranchTaken=1 gives IFIDFlush=1 for 1 cycle.
REQ-031 SHALL cover the $0 case:
- Stimulus: load to $0 in EX; ID reads $0.
- Response: no stall; PCWrite=1.
REQ-032 SHALL cover divide occupancy:
- Stimulus: MdStart_IDEX=1, MdIsDiv_IDEX=1; mfhi in ID on the following cycles.
- Response: MdBusy=1 for 32 cycles; mfhi stalled until MdBusy falls; StallCount=32.
REQ-033 SHALL cover stall/branch collision:
- Stimulus: BranchTaken=1 and BrAlu=1 in the same cycle.
- Response: IFIDFlush=0, IDEXFlush=1, PCWrite=0.
REQ-034 SHALL cover reset mid-operation:
- Stimulus: rst_n=0 during MDW with MdCnt=10.
- Response: next edge MdBusy=0, StallCount=0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use, branch-operand and mult/div
// result hazards in ID, and drives stall/flush controls plus a stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Opcode_IFID,
    input  logic [5:0]  Funct_IFID,
    input  logic [4:0]  RsAddr_IFID,
    input  logic [4:0]  RtAddr_IFID,
    input  logic [4:0]  RdAddr_IDEX,
    input  logic        RegWrite_IDEX,
    input  logic        MemRead_IDEX,
    input  logic [4:0]  RdAddr_EXMEM,
    input  logic        MemRead_EXMEM,
    input  logic        BranchTaken,
    input  logic        Jump,
    input  logic        MdStart_IDEX,
    input  logic        MdIsDiv_IDEX,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MdBusy,
    output logic [15:0] StallCount
);

    typedef enum logic {
        RUN = 1'b0,
        MDW = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic br_ab, br_a, is_branch, uses_rt;
    logic rs_match_ex, rt_match_ex, rs_match_mem, rt_match_mem;
    logic src_match_ex, src_match_mem;
    logic load_use, br_alu, br_ld_mem, md_read, md_haz, stall;

    assign MdBusy     = (state_q == MDW);
    assign StallCount = stall_cnt_q;

    // Register-0 never creates a dependency; rt only counts when the opcode reads it.
    always_comb begin
        br_ab     = (Opcode_IFID == 6'h04) || (Opcode_IFID == 6'h05);
        br_a      = (Opcode_IFID == 6'h01) || (Opcode_IFID == 6'h06) || (Opcode_IFID == 6'h07);
        is_branch = br_ab || br_a;
        uses_rt   = (Opcode_IFID == 6'h00) || br_ab || (Opcode_IFID == 6'h2B);

        rs_match_ex   = (RsAddr_IFID != 5'd0) && (RsAddr_IFID == RdAddr_IDEX);
        rt_match_ex   = uses_rt && (RtAddr_IFID != 5'd0) && (RtAddr_IFID == RdAddr_IDEX);
        rs_match_mem  = (RsAddr_IFID != 5'd0) && (RsAddr_IFID == RdAddr_EXMEM);
        rt_match_mem  = uses_rt && (RtAddr_IFID != 5'd0) && (RtAddr_IFID == RdAddr_EXMEM);
        src_match_ex  = rs_match_ex || rt_match_ex;
        src_match_mem = rs_match_mem || rt_match_mem;

        load_use  = MemRead_IDEX && src_match_ex;
        br_alu    = is_branch && RegWrite_IDEX && !MemRead_IDEX && src_match_ex;
        br_ld_mem = is_branch && MemRead_EXMEM && src_match_mem;

        md_read = (Opcode_IFID == 6'h00) &&
                  (Funct_IFID inside {6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B});
        // A unit starting this cycle is already busy from the ID instruction's view.
        md_haz  = (MdBusy || MdStart_IDEX) && md_read;

        stall = load_use || br_alu || br_ld_mem || md_haz;
    end

    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (!rst_n) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (stall) begin
            // Stall takes priority over a taken branch or jump.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (Jump || (is_branch && BranchTaken)) begin
            IFIDFlush = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (MdStart_IDEX) begin
                    state_d  = MDW;
                    md_cnt_d = MdIsDiv_IDEX ? 6'd32 : 6'd4;
                end
            end
            MDW: begin
                if (md_cnt_q == 6'd1) begin
                    state_d  = RUN;
                    md_cnt_d = 6'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            default: state_d = RUN;
        endcase
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            md_cnt_q    <= 6'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes expected outputs into a
// scoreboard queue, an independent monitor pops and compares each cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  Opcode_IFID = '0, Funct_IFID = '0;
    logic [4:0]  RsAddr_IFID = '0, RtAddr_IFID = '0;
    logic [4:0]  RdAddr_IDEX = '0, RdAddr_EXMEM = '0;
    logic        RegWrite_IDEX = 0, MemRead_IDEX = 0, MemRead_EXMEM = 0;
    logic        BranchTaken = 0, Jump = 0, MdStart_IDEX = 0, MdIsDiv_IDEX = 0;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdBusy;
    logic [15:0] StallCount;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .Opcode_IFID(Opcode_IFID), .Funct_IFID(Funct_IFID),
        .RsAddr_IFID(RsAddr_IFID), .RtAddr_IFID(RtAddr_IFID),
        .RdAddr_IDEX(RdAddr_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .RdAddr_EXMEM(RdAddr_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
        .BranchTaken(BranchTaken), .Jump(Jump),
        .MdStart_IDEX(MdStart_IDEX), .MdIsDiv_IDEX(MdIsDiv_IDEX),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .MdBusy(MdBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    localparam logic [3:0] CTL_RUN   = 4'b1100;
    localparam logic [3:0] CTL_STALL = 4'b0001;
    localparam logic [3:0] CTL_FLUSH = 4'b1110;
    localparam logic [3:0] CTL_RST   = 4'b0011;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic        busy;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_sc  = 16'd0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [20:0] got, want;
            e    = sb.pop_front();
            got  = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdBusy, StallCount};
            want = {e.ctl, e.busy, e.sc};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b busy=%b sc=%0d, expected ctl=%b busy=%b sc=%0d",
                         e.name, got[20:17], got[16], got[15:0], e.ctl, e.busy, e.sc);
            end else begin
                $display("[TB] ok %s ctl=%b busy=%b sc=%0d", e.name, e.ctl, e.busy, e.sc);
            end
        end
    end

    task automatic begin_cyc();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        Opcode_IFID = '0; Funct_IFID = '0; RsAddr_IFID = '0; RtAddr_IFID = '0;
        RdAddr_IDEX = '0; RegWrite_IDEX = 0; MemRead_IDEX = 0;
        RdAddr_EXMEM = '0; MemRead_EXMEM = 0;
        BranchTaken = 0; Jump = 0; MdStart_IDEX = 0; MdIsDiv_IDEX = 0;
    endtask

    // Expected StallCount is the value before this cycle's edge; a stall adds one after.
    task automatic expect_out(input string name, input logic [3:0] ctl, input logic busy);
        exp_t e;
        e.name = name; e.ctl = ctl; e.busy = busy; e.sc = exp_sc;
        sb.push_back(e);
        if (!rst_n) exp_sc = 16'd0;
        else if (ctl == CTL_STALL) exp_sc = exp_sc + 16'd1;
    endtask

    initial begin
        // Reset held from time zero with a load-use hazard and taken branch present
        @(posedge clk); #1;
        Opcode_IFID = 6'h00; RsAddr_IFID = 5'd8; MemRead_IDEX = 1; RdAddr_IDEX = 5'd8; BranchTaken = 1;
        expect_out("reset", CTL_RST, 1'b0);

        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd1; RtAddr_IFID = 5'd2;
        expect_out("idle_add", CTL_RUN, 1'b0);

        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd8; MemRead_IDEX = 1; RdAddr_IDEX = 5'd8; RegWrite_IDEX = 1;
        expect_out("load_use_rs", CTL_STALL, 1'b0);
        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd8;
        expect_out("load_use_release", CTL_RUN, 1'b0);

        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd3; RtAddr_IFID = 5'd8; MemRead_IDEX = 1; RdAddr_IDEX = 5'd8;
        expect_out("load_use_rt", CTL_STALL, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h08; RsAddr_IFID = 5'd3; RtAddr_IFID = 5'd8; MemRead_IDEX = 1; RdAddr_IDEX = 5'd8;
        expect_out("addi_rt_unused", CTL_RUN, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h2B; RsAddr_IFID = 5'd3; RtAddr_IFID = 5'd8; MemRead_IDEX = 1; RdAddr_IDEX = 5'd8;
        expect_out("sw_rt_used", CTL_STALL, 1'b0);
        begin_cyc(); Funct_IFID = 6'h20; MemRead_IDEX = 1; RdAddr_IDEX = 5'd0;
        expect_out("load_to_r0", CTL_RUN, 1'b0);

        // lw $9 then beq $9: two stalls, then the branch resolves and flushes IF/ID
        begin_cyc(); Opcode_IFID = 6'h04; RsAddr_IFID = 5'd9; RtAddr_IFID = 5'd3;
        MemRead_IDEX = 1; RegWrite_IDEX = 1; RdAddr_IDEX = 5'd9; BranchTaken = 1;
        expect_out("br_load_ex", CTL_STALL, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h04; RsAddr_IFID = 5'd9; RtAddr_IFID = 5'd3;
        MemRead_EXMEM = 1; RdAddr_EXMEM = 5'd9; BranchTaken = 1;
        expect_out("br_load_mem", CTL_STALL, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h04; RsAddr_IFID = 5'd9; RtAddr_IFID = 5'd3; BranchTaken = 1;
        expect_out("br_taken", CTL_FLUSH, 1'b0);
        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd1;
        expect_out("after_branch", CTL_RUN, 1'b0);

        begin_cyc(); Opcode_IFID = 6'h05; RsAddr_IFID = 5'd4; RtAddr_IFID = 5'd5;
        RegWrite_IDEX = 1; RdAddr_IDEX = 5'd5; BranchTaken = 1;
        expect_out("br_alu_collision", CTL_STALL, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h01; RsAddr_IFID = 5'd6; RtAddr_IFID = 5'd7;
        RegWrite_IDEX = 1; RdAddr_IDEX = 5'd7;
        expect_out("bltz_rt_unused", CTL_RUN, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h07; RsAddr_IFID = 5'd6; RegWrite_IDEX = 1; RdAddr_IDEX = 5'd6;
        expect_out("bgtz_alu_rs", CTL_STALL, 1'b0);
        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd5; RegWrite_IDEX = 1; RdAddr_IDEX = 5'd5;
        expect_out("alu_forwarded", CTL_RUN, 1'b0);
        begin_cyc(); Funct_IFID = 6'h20; RsAddr_IFID = 5'd9; MemRead_EXMEM = 1; RdAddr_EXMEM = 5'd9;
        expect_out("mem_load_nonbranch", CTL_RUN, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h02; Jump = 1;
        expect_out("jump", CTL_FLUSH, 1'b0);
        begin_cyc(); Opcode_IFID = 6'h00; BranchTaken = 1;
        expect_out("bt_nonbranch", CTL_RUN, 1'b0);

        // Multiply: 4 busy cycles; a restart request while busy is ignored
        begin_cyc(); MdStart_IDEX = 1;
        expect_out("mult_start", CTL_RUN, 1'b0);
        for (int i = 0; i < 4; i++) begin
            begin_cyc(); Funct_IFID = 6'h12;
            if (i == 1) begin MdStart_IDEX = 1; MdIsDiv_IDEX = 1; end
            expect_out($sformatf("mult_wait%0d", i), CTL_STALL, 1'b1);
        end
        begin_cyc(); Funct_IFID = 6'h12;
        expect_out("mult_done", CTL_RUN, 1'b0);
        begin_cyc(); Funct_IFID = 6'h10; MdStart_IDEX = 1;
        expect_out("mfhi_with_start", CTL_STALL, 1'b0);
        for (int i = 0; i < 4; i++) begin
            begin_cyc(); expect_out($sformatf("mult2_wait%0d", i), CTL_RUN, 1'b1);
        end

        // Divide from a cleared counter: 32 busy cycles, 32 stalls
        begin_cyc(); rst_n = 0;
        expect_out("reset2", CTL_RST, 1'b0);
        begin_cyc(); MdStart_IDEX = 1; MdIsDiv_IDEX = 1;
        expect_out("div_start", CTL_RUN, 1'b0);
        for (int i = 0; i < 32; i++) begin
            begin_cyc(); Funct_IFID = 6'h10;
            expect_out($sformatf("div_wait%0d", i), CTL_STALL, 1'b1);
        end
        begin_cyc(); Funct_IFID = 6'h10;
        expect_out("div_done_sc32", CTL_RUN, 1'b0);

        // Reset while the divider has 10 cycles left
        begin_cyc(); MdStart_IDEX = 1; MdIsDiv_IDEX = 1;
        expect_out("div2_start", CTL_RUN, 1'b0);
        for (int i = 0; i < 22; i++) begin
            begin_cyc(); expect_out($sformatf("div2_wait%0d", i), CTL_RUN, 1'b1);
        end
        begin_cyc(); rst_n = 0; Funct_IFID = 6'h10;
        expect_out("reset_mid_mdw", CTL_RST, 1'b1);
        begin_cyc(); Funct_IFID = 6'h10;
        expect_out("post_reset_mfhi", CTL_RUN, 1'b0);
        begin_cyc(); Funct_IFID = 6'h18;
        expect_out("post_reset_mult", CTL_RUN, 1'b0);

        begin_cyc();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
